// File: rtl/incr_share_arbiter_if.sv
// Request/grant/counter bundle between counter-using logic and the shared-incrementer arbiter.
interface incr_share_arbiter_if #(
  parameter int N_CNT = 4,
  parameter int IDX_W = 2
);
  logic [N_CNT-1:0]   req;
  logic [N_CNT-1:0]   clr;
  logic [N_CNT-1:0]   ack;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [4*N_CNT-1:0] cnt;
  logic [N_CNT-1:0]   wrap;

  modport master (output req, clr, input ack, gnt_idx, gnt_vld, cnt, wrap);
  modport slave  (input req, clr, output ack, gnt_idx, gnt_vld, cnt, wrap);
endinterface

// File: rtl/incr_share_arbiter.sv
// Round-robin arbiter owning N_CNT 4-bit counters that share a single add_by_one incrementer.
module add_by_one (
  input  logic [3:0] a,
  output logic [3:0] y
);
  assign y = a + 4'd1;
endmodule

module incr_share_arbiter #(
  parameter int N_CNT = 4,
  parameter int IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  incr_share_arbiter_if.slave  bus
);

  logic [IDX_W-1:0] ptr_p1;
  logic [3:0]       cnt_p1 [N_CNT];
  logic [N_CNT-1:0] wrap_p1;

  logic [N_CNT-1:0] elig_p0;
  logic [N_CNT-1:0] ack_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             vld_p0;
  logic [IDX_W-1:0] sel_p0;
  int               pos_p0;
  logic [3:0]       inc_a;
  logic [3:0]       inc_y;

  // Stage p0: combinational search from ptr upward, wrapping modulo N_CNT; cnt never feeds this path.
  always_comb begin
    elig_p0 = bus.req & ~bus.clr;
    ack_p0  = '0;
    idx_p0  = '0;
    vld_p0  = 1'b0;
    pos_p0  = 0;
    sel_p0  = '0;
    if (!rst) begin
      for (int k = 0; k < N_CNT; k++) begin
        pos_p0 = int'(ptr_p1) + k;
        if (pos_p0 >= N_CNT) pos_p0 = pos_p0 - N_CNT;
        sel_p0 = IDX_W'(pos_p0);
        if (!vld_p0 && elig_p0[sel_p0]) begin
          vld_p0         = 1'b1;
          idx_p0         = sel_p0;
          ack_p0[sel_p0] = 1'b1;
        end
      end
    end
  end

  assign inc_a = cnt_p1[idx_p0];

  add_by_one u_inc (
    .a (inc_a),
    .y (inc_y)
  );

  // Stage p1: write-back of the granted counter, wrap pulse and pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p1  <= '0;
      wrap_p1 <= '0;
      for (int i = 0; i < N_CNT; i++) cnt_p1[i] <= 4'd0;
    end else begin
      if (vld_p0) ptr_p1 <= (idx_p0 == IDX_W'(N_CNT - 1)) ? '0 : idx_p0 + 1'b1;
      for (int i = 0; i < N_CNT; i++) begin
        wrap_p1[i] <= ack_p0[i] && (cnt_p1[i] == 4'hF);
        if (bus.clr[i])     cnt_p1[i] <= 4'd0;
        else if (ack_p0[i]) cnt_p1[i] <= inc_y;
      end
    end
  end

  assign bus.ack     = ack_p0;
  assign bus.gnt_idx = idx_p0;
  assign bus.gnt_vld = vld_p0;
  assign bus.wrap    = wrap_p1;

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    assign bus.cnt[4*g +: 4] = cnt_p1[g];
  end

endmodule

// File: tb/tb_incr_share_arbiter.sv
// Bench for incr_share_arbiter: directed scenarios plus random traffic against a queue-free behavioural model.
module tb_incr_share_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  incr_share_arbiter_if #(.N_CNT(N), .IDX_W(IW)) bus ();

  incr_share_arbiter #(.N_CNT(N), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests_run = 0;
  int failed    = 0;

  int         mcnt [N];
  int         mptr;
  logic [N-1:0] mwrap;
  int         eg;
  logic       ev;

  function automatic void model_grant(input logic r, input logic [N-1:0] q, input logic [N-1:0] c);
    ev = 1'b0;
    eg = 0;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (!ev && q[i] && !c[i]) begin
          ev = 1'b1;
          eg = i;
        end
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_ack();
    logic [N-1:0] a;
    a = '0;
    if (ev) a[eg] = 1'b1;
    return a;
  endfunction

  function automatic logic [4*N-1:0] exp_cnt();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(mcnt[i]);
    return v;
  endfunction

  task automatic drive(input logic r, input logic [N-1:0] q, input logic [N-1:0] c);
    rst     = r;
    bus.req = q;
    bus.clr = c;
    model_grant(r, q, c);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      mptr  = 0;
      mwrap = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        mwrap[i] = ev && (eg == i) && (mcnt[i] == 15);
        if (bus.clr[i])             mcnt[i] = 0;
        else if (ev && (eg == i))   mcnt[i] = (mcnt[i] + 1) % 16;
      end
      if (ev) mptr = (eg + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, '0, '0);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 4'hF, 4'h0);
    tests_run++;
    if (bus.ack !== 4'b0000) begin failed++; $display("FAIL reset_ack got %b want 0000", bus.ack); end
    tests_run++;
    if (bus.gnt_vld !== 1'b0) begin failed++; $display("FAIL reset_vld got %b want 0", bus.gnt_vld); end
    tick();
    tests_run++;
    if (bus.cnt !== 16'h0000) begin failed++; $display("FAIL reset_cnt got %h want 0000", bus.cnt); end
    tests_run++;
    if (bus.wrap !== 4'b0000) begin failed++; $display("FAIL reset_wrap got %b want 0000", bus.wrap); end
  endtask

  task automatic test_single();
    int wraps;
    wraps = 0;
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, 4'b0100, 4'b0000);
      tests_run++;
      if (bus.ack !== 4'b0100) begin failed++; $display("FAIL single_ack cyc %0d got %b want 0100", k, bus.ack); end
      tick();
      tests_run++;
      if (bus.cnt !== exp_cnt()) begin failed++; $display("FAIL single_cnt cyc %0d got %h want %h", k, bus.cnt, exp_cnt()); end
      tests_run++;
      if (bus.wrap !== mwrap) begin failed++; $display("FAIL single_wrap cyc %0d got %b want %b", k, bus.wrap, mwrap); end
      if (bus.wrap[2]) wraps++;
    end
    tests_run++;
    if (bus.cnt[11:8] !== 4'd1) begin failed++; $display("FAIL single_final got %0d want 1", bus.cnt[11:8]); end
    tests_run++;
    if (wraps != 1) begin failed++; $display("FAIL single_wrapcount got %0d want 1", wraps); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 4'hF, 4'h0);
      tests_run++;
      if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== IW'(k % 4)) begin
        failed++; $display("FAIL rr_grant cyc %0d got vld=%b idx=%0d want idx %0d", k, bus.gnt_vld, bus.gnt_idx, k % 4);
      end
      tests_run++;
      if (bus.ack !== exp_ack()) begin failed++; $display("FAIL rr_ack cyc %0d got %b want %b", k, bus.ack, exp_ack()); end
      tick();
    end
    tests_run++;
    if (bus.cnt !== 16'h2222) begin failed++; $display("FAIL rr_cnt got %h want 2222", bus.cnt); end
  endtask

  task automatic test_ptr_skip();
    int want [3] = '{3, 0, 3};
    do_reset();
    drive(1'b0, 4'b0010, 4'b0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b1001, 4'b0000);
      tests_run++;
      if (bus.gnt_vld !== 1'b1 || bus.gnt_idx !== IW'(want[k])) begin
        failed++; $display("FAIL skip_grant step %0d got vld=%b idx=%0d want %0d", k, bus.gnt_vld, bus.gnt_idx, want[k]);
      end
      tick();
      tests_run++;
      if (bus.cnt !== exp_cnt()) begin failed++; $display("FAIL skip_cnt step %0d got %h want %h", k, bus.cnt, exp_cnt()); end
    end
  endtask

  task automatic test_clear_collision();
    int vals [2] = '{7, 15};
    for (int v = 0; v < 2; v++) begin
      do_reset();
      for (int k = 0; k < vals[v]; k++) begin
        drive(1'b0, 4'b0010, 4'b0000);
        tick();
      end
      drive(1'b0, 4'b0001, 4'b0000);
      tick();
      tests_run++;
      if (bus.cnt[7:4] !== 4'(vals[v])) begin failed++; $display("FAIL clr_setup got %0d want %0d", bus.cnt[7:4], vals[v]); end
      drive(1'b0, 4'b0011, 4'b0010);
      tests_run++;
      if (bus.ack !== 4'b0001) begin failed++; $display("FAIL clr_ack val %0d got %b want 0001", vals[v], bus.ack); end
      tick();
      tests_run++;
      if (bus.cnt[7:0] !== 8'h02) begin failed++; $display("FAIL clr_cnt val %0d got %h want 02", vals[v], bus.cnt[7:0]); end
      tests_run++;
      if (bus.wrap !== 4'b0000) begin failed++; $display("FAIL clr_wrap val %0d got %b want 0000", vals[v], bus.wrap); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b0010, 4'b0000);
      tick();
    end
    drive(1'b0, 4'b0010, 4'b0000);
    tests_run++;
    if (bus.ack !== 4'b0010) begin failed++; $display("FAIL mid_pre_ack got %b want 0010", bus.ack); end
    drive(1'b1, 4'b0010, 4'b0000);
    tests_run++;
    if (bus.ack !== 4'b0000) begin failed++; $display("FAIL mid_rst_ack got %b want 0000", bus.ack); end
    tick();
    tests_run++;
    if (bus.cnt[7:4] !== 4'd0) begin failed++; $display("FAIL mid_cnt got %0d want 0", bus.cnt[7:4]); end
    drive(1'b0, 4'b1001, 4'b0000);
    tests_run++;
    if (bus.gnt_idx !== 2'd0 || bus.gnt_vld !== 1'b1) begin
      failed++; $display("FAIL mid_ptr got vld=%b idx=%0d want idx 0", bus.gnt_vld, bus.gnt_idx);
    end
    tick();
    drive(1'b0, 4'b0010, 4'b0000);
    tests_run++;
    if (bus.ack !== 4'b0010) begin failed++; $display("FAIL mid_rel_ack got %b want 0010", bus.ack); end
    tick();
    tests_run++;
    if (bus.cnt[7:4] !== 4'd1) begin failed++; $display("FAIL mid_rel_cnt got %0d want 1", bus.cnt[7:4]); end
  endtask

  task automatic test_random();
    logic r;
    logic [N-1:0] q, c;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 40) == 0);
      q = N'($urandom);
      c = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      drive(r, q, c);
      tests_run++;
      if (bus.ack !== exp_ack() || bus.gnt_vld !== ev || (ev && bus.gnt_idx !== IW'(eg))) begin
        failed++;
        $display("FAIL rand_grant cyc %0d got ack=%b vld=%b idx=%0d want ack=%b vld=%b idx=%0d",
                 k, bus.ack, bus.gnt_vld, bus.gnt_idx, exp_ack(), ev, eg);
      end
      tick();
      tests_run++;
      if (bus.cnt !== exp_cnt() || bus.wrap !== mwrap) begin
        failed++;
        $display("FAIL rand_state cyc %0d got cnt=%h wrap=%b want cnt=%h wrap=%b",
                 k, bus.cnt, bus.wrap, exp_cnt(), mwrap);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    mptr  = 0;
    mwrap = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_skip();
    test_clear_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/incr_share_arbiter.md
# incr_share_arbiter

Round-robin arbiter and register bank that lets N_CNT independent 4-bit up-counters share one `add_by_one` incrementer. Each cycle at most one requesting counter is granted. Its value is routed through the single incrementer and written back. The block sits between counter-using logic (event tallies, display digits) and the shared incrementer datapath, and it owns every counter register.

## Interface
- N_CNT, 4, number of counters/requesters; legal range 2..8
- IDX_W, 2, width of the grant index; must equal clog2(N_CNT)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  N_CNT  level request per counter; bit i high means "increment counter i"
- clr  in  N_CNT  synchronous clear per counter
- ack  out  N_CNT  one-hot grant; combinational; an increment of counter i occurs in any cycle where req[i] and ack[i] are both high
- gnt_idx  out  IDX_W  index of the granted counter; valid only when gnt_vld is high
- gnt_vld  out  1  high when any ack bit is high
- cnt  out  4*N_CNT  registered counter values; counter i is cnt[4*i+3:4*i]
- wrap  out  N_CNT  registered one-cycle pulse; counter i wrapped from 15 to 0 on the previous edge

## Operation
- State:
  - cnt[i] is 4 bits.
  - ptr is IDX_W bits; it is the round-robin start position.
- Eligibility: elig[i] = req[i] & ~clr[i].
- Arbitration (combinational):
  - Search from ptr upward, wrapping modulo N_CNT.
  - The first eligible index is granted.
  - No eligible bit means no grant.
- Exactly one `add_by_one` instance. Its input is muxed from cnt[gnt_idx]; its output is written to cnt[gnt_idx] at the edge.
- Per-counter next state, in priority order:
  1. rst: cnt[i] <= 0.
  2. clr[i]: cnt[i] <= 0.
  3. ack[i]: cnt[i] <= cnt[i]+1 mod 16.
  4. Otherwise: cnt[i] holds.
- wrap[i] <= ack[i] & (cnt[i]==4'hF). It is cleared the following cycle unless the condition repeats. A clear from 15 does not raise wrap.
- ptr update:
  - On a grant to i: ptr <= (i+1) mod N_CNT.
  - No grant: ptr holds.
  - clr never moves ptr.
- Requesters may hold req high continuously. A held request is incremented once per grant.
- Fairness: a continuously asserted, non-cleared request is granted within N_CNT cycles.
- Indices ≥ N_CNT do not exist. The ptr wrap uses explicit modulo, not power-of-two overflow, when N_CNT is not a power of 2.

## Timing
- Reset values:
  - cnt = 0, wrap = 0, ptr = 0.
  - ack, gnt_vld and gnt_idx are forced to 0 while rst is high, whatever req is.
- Latency:
  - ack follows req combinationally in the same cycle.
  - The new count is visible on cnt one cycle after the ack cycle.
  - wrap pulses in that same cycle.
- Throughput: one increment per cycle total, across all counters.
- Simultaneous events:
  - req[i] and clr[i] together: the clear wins, there is no ack[i], and another eligible requester may be granted that cycle.
  - clr on a non-granted counter proceeds in parallel with a grant to another counter.
- Reset mid-operation: rst overrides any pending grant. There is no increment, ptr returns to 0, and requests simply re-arbitrate after rst drops.
- No combinational path from cnt to ack. The ack path depends only on req, clr, ptr and rst.

## Test plan
- Reset: after rst, cnt = 0 for every counter and wrap = 0; drive req=4'hF during rst -> ack=0, gnt_vld=0.
- Single requester: req=4'b0100 held 17 cycles from reset -> ack=4'b0100 every cycle. Counter 2 ends at 1, and wrap[2] pulses once, in the cycle cnt[2] reads 0 after the 16th increment.
- Round-robin: req=4'hF held 8 cycles from reset -> grants in order 0,1,2,3,0,1,2,3; each counter ends at 2.
- Ptr skip: ptr=2 (after a grant to 1), req=4'b1001 -> grant 3, then grant 0, then grant 3.
- Clear collision: cnt[1]=7, req=4'b0011, clr=4'b0010, ptr=1 -> ack=4'b0001, cnt[1]=0 and cnt[0] incremented next cycle, wrap=0. Repeat with cnt[1]=15 -> still wrap=0.
- Reset mid-run: assert rst in the same cycle as ack=4'b0010 with cnt[1]=5 -> next cycle cnt[1]=0, ptr=0; release with req=4'b0010 -> ack=4'b0010, cnt[1]=1 one cycle later.
